mem_stage: RTL and testbench

- MEM stage of the five-stage MIPS pipeline, fused with the M/W pipeline register.
- Holds the word-addressed data memory and performs sw/sh/sb stores with byte-lane enables.
- Aligns lb/lbu/lh/lhu load data down to bit 0, so the write-back stage only zero- or sign-extends the low byte or halfword.
- Registers instruction, PC, ALU result, load data and destination register for the write-back stage.

---
 rtl/mem_stage.sv | 104 ++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage fused with the M/W pipeline register.
// Byte-lane data memory, load alignment and write-back bundle capture.
module mem_stage #(
  parameter int DM_DEPTH = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instruc,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_AluRe,
  input  logic [31:0] M_WRD,
  input  logic [4:0]  M_WRA,
  input  logic        M_MemWrite,
  input  logic [1:0]  M_StoreOp,
  input  logic [1:0]  M_LoadOp,
  output logic [31:0] W_instruc,
  output logic [31:0] W_PC,
  output logic [31:0] W_AluRe,
  output logic [31:0] W_DM,
  output logic [4:0]  W_WRA
);

  logic [31:0] r_mem [DM_DEPTH];

  logic [DM_AW-1:0] w_idx;
  logic [1:0]       w_off;
  logic [31:0]      w_rd;
  logic [31:0]      w_rd_b;
  logic [31:0]      w_rd_h;
  logic [31:0]      w_aligned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  assign w_idx  = M_AluRe[DM_AW+1:2];
  assign w_off  = M_AluRe[1:0];
  assign w_rd   = r_mem[w_idx];
  assign w_rd_b = w_rd >> {w_off, 3'b000};
  assign w_rd_h = w_rd >> {w_off[1], 4'b0000};

  always_comb begin
    w_aligned = w_rd;
    unique case (M_LoadOp)
      2'b01:   w_aligned = {24'b0, w_rd_b[7:0]};
      2'b10:   w_aligned = {16'b0, w_rd_h[15:0]};
      default: w_aligned = w_rd;
    endcase
  end

  // Store data is replicated across lanes; the enables pick the target.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = M_WRD;
    unique case (M_StoreOp)
      2'b00: begin
        w_be    = 4'b1111;
        w_wdata = M_WRD;
      end
      2'b01: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{M_WRD[7:0]}};
      end
      2'b10: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{M_WRD[15:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = M_WRD;
      end
    endcase
    if (!M_MemWrite) w_be = 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_be[0]) r_mem[w_idx][7:0]   <= w_wdata[7:0];
      if (w_be[1]) r_mem[w_idx][15:8]  <= w_wdata[15:8];
      if (w_be[2]) r_mem[w_idx][23:16] <= w_wdata[23:16];
      if (w_be[3]) r_mem[w_idx][31:24] <= w_wdata[31:24];
    end
  end

  // W_DM samples the pre-write word, giving read-before-write ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_instruc <= '0;
      W_PC      <= '0;
      W_AluRe   <= '0;
      W_DM      <= '0;
      W_WRA     <= '0;
    end else begin
      W_instruc <= M_instruc;
      W_PC      <= M_PC;
      W_AluRe   <= M_AluRe;
      W_DM      <= w_aligned;
      W_WRA     <= M_WRA;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Hand-computed expectations checked with immediate assertions.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] M_instruc;
  logic [31:0] M_PC;
  logic [31:0] M_AluRe;
  logic [31:0] M_WRD;
  logic [4:0]  M_WRA;
  logic        M_MemWrite;
  logic [1:0]  M_StoreOp;
  logic [1:0]  M_LoadOp;
  logic [31:0] W_instruc;
  logic [31:0] W_PC;
  logic [31:0] W_AluRe;
  logic [31:0] W_DM;
  logic [4:0]  W_WRA;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.DM_DEPTH(1024), .DM_AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_instruc  (M_instruc),
    .M_PC       (M_PC),
    .M_AluRe    (M_AluRe),
    .M_WRD      (M_WRD),
    .M_WRA      (M_WRA),
    .M_MemWrite (M_MemWrite),
    .M_StoreOp  (M_StoreOp),
    .M_LoadOp   (M_LoadOp),
    .W_instruc  (W_instruc),
    .W_PC       (W_PC),
    .W_AluRe    (W_AluRe),
    .W_DM       (W_DM),
    .W_WRA      (W_WRA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] pc,
                       input logic [31:0] addr,
                       input logic [31:0] wrd,
                       input logic [4:0]  wra,
                       input logic        mw,
                       input logic [1:0]  sop,
                       input logic [1:0]  lop);
    M_instruc  = ins;
    M_PC       = pc;
    M_AluRe    = addr;
    M_WRD      = wrd;
    M_WRA      = wra;
    M_MemWrite = mw;
    M_StoreOp  = sop;
    M_LoadOp   = lop;
  endtask

  task automatic step(input logic [31:0] ins,
                      input logic [31:0] pc,
                      input logic [31:0] addr,
                      input logic [31:0] wrd,
                      input logic [4:0]  wra,
                      input logic        mw,
                      input logic [1:0]  sop,
                      input logic [1:0]  lop);
    drive(ins, pc, addr, wrd, wra, mw, sop, lop);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive('0, '0, '0, '0, '0, 1'b0, 2'b00, 2'b00);

    // held in reset with a store pending
    repeat (3) step(32'hAC00_0000, 32'h40, 32'h0,
                    32'hFFFF_FFFF, 5'd3, 1'b1, 2'b00, 2'b00);
    check("rst_instruc", W_instruc, 32'h0);
    check("rst_pc", W_PC, 32'h0);
    check("rst_alu", W_AluRe, 32'h0);
    check("rst_dm", W_DM, 32'h0);
    check("rst_wra", {27'b0, W_WRA}, 32'h0);

    reset = 1'b1;
    step(32'h8C01_0000, 32'h44, 32'h0, 32'h0, 5'd1,
         1'b0, 2'b00, 2'b00);
    check("post_rst_lw0", W_DM, 32'h0);
    check("post_rst_ins", W_instruc, 32'h8C01_0000);

    // word store then load
    step(32'hAC02_0010, 32'h100, 32'h10, 32'h1234_5678, 5'd0,
         1'b1, 2'b00, 2'b00);
    check("sw_rbw", W_DM, 32'h0);
    step(32'h8C07_0010, 32'h104, 32'h10, 32'h0, 5'd7,
         1'b0, 2'b00, 2'b00);
    check("lw_10", W_DM, 32'h1234_5678);
    check("lw_10_pc", W_PC, 32'h104);
    check("lw_10_wra", {27'b0, W_WRA}, 32'd7);
    check("lw_10_alu", W_AluRe, 32'h10);

    // byte lanes
    step(32'h1, 32'h108, 32'h20, 32'hAABB_CCDD, 5'd0,
         1'b1, 2'b00, 2'b00);
    step(32'h2, 32'h10C, 32'h22, 32'hFFFF_FF11, 5'd0,
         1'b1, 2'b01, 2'b00);
    check("sb_rbw", W_DM, 32'hAABB_CCDD);
    step(32'h3, 32'h110, 32'h20, 32'h0, 5'd2,
         1'b0, 2'b00, 2'b00);
    check("lw_20", W_DM, 32'hAA11_CCDD);
    step(32'h4, 32'h114, 32'h23, 32'h0, 5'd2,
         1'b0, 2'b00, 2'b01);
    check("lb_23", W_DM, 32'h0000_00AA);
    step(32'h5, 32'h118, 32'h21, 32'h0, 5'd2,
         1'b0, 2'b00, 2'b01);
    check("lb_21", W_DM, 32'h0000_00CC);
    step(32'h6, 32'h11C, 32'h22, 32'h0, 5'd2,
         1'b0, 2'b00, 2'b11);
    check("lop11_word", W_DM, 32'hAA11_CCDD);

    // halfword lanes
    step(32'h7, 32'h120, 32'h26, 32'h1234_BEEF, 5'd0,
         1'b1, 2'b10, 2'b00);
    step(32'h8, 32'h124, 32'h24, 32'h0, 5'd4,
         1'b0, 2'b00, 2'b00);
    check("lw_24", W_DM, 32'hBEEF_0000);
    step(32'h9, 32'h128, 32'h24, 32'h0, 5'd4,
         1'b0, 2'b00, 2'b10);
    check("lh_24", W_DM, 32'h0);
    step(32'hA, 32'h12C, 32'h27, 32'h0, 5'd4,
         1'b0, 2'b00, 2'b10);
    check("lh_27", W_DM, 32'h0000_BEEF);

    // wrap, reserved store op, disabled write
    step(32'hB, 32'h130, 32'h1000, 32'hCAFE_F00D, 5'd0,
         1'b1, 2'b00, 2'b00);
    step(32'hC, 32'h134, 32'h0, 32'h0, 5'd5,
         1'b0, 2'b00, 2'b00);
    check("wrap_lw0", W_DM, 32'hCAFE_F00D);
    check("wrap_alu", W_AluRe, 32'h0);
    step(32'hD, 32'h138, 32'h0, 32'hDEAD_BEEF, 5'd0,
         1'b1, 2'b11, 2'b00);
    step(32'hE, 32'h13C, 32'h0, 32'h0, 5'd5,
         1'b0, 2'b00, 2'b00);
    check("sop11_nowr", W_DM, 32'hCAFE_F00D);
    step(32'hF, 32'h140, 32'h0, 32'h0000_0001, 5'd0,
         1'b0, 2'b00, 2'b00);
    step(32'h10, 32'h144, 32'h0, 32'h0, 5'd5,
         1'b0, 2'b00, 2'b00);
    check("mw0_nowr", W_DM, 32'hCAFE_F00D);

    // bubble
    step('0, '0, '0, '0, '0, 1'b0, 2'b00, 2'b00);
    check("bub_ins", W_instruc, 32'h0);
    check("bub_pc", W_PC, 32'h0);
    check("bub_wra", {27'b0, W_WRA}, 32'h0);

    // asynchronous reset mid-operation
    step(32'h8C09_0010, 32'h200, 32'h10, 32'h0, 5'd9,
         1'b0, 2'b00, 2'b00);
    check("pre_arst_dm", W_DM, 32'h1234_5678);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ins", W_instruc, 32'h0);
    check("arst_pc", W_PC, 32'h0);
    check("arst_alu", W_AluRe, 32'h0);
    check("arst_dm", W_DM, 32'h0);
    check("arst_wra", {27'b0, W_WRA}, 32'h0);
    #3;
    reset = 1'b1;
    step(32'h8C09_0010, 32'h204, 32'h10, 32'h0, 5'd9,
         1'b0, 2'b00, 2'b00);
    check("arst_mem10", W_DM, 32'h0);
    step(32'h8C09_0020, 32'h208, 32'h20, 32'h0, 5'd9,
         1'b0, 2'b00, 2'b00);
    check("arst_mem20", W_DM, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
